// File: rtl/alu_pkg.sv
// Shared opcode, function, state and flag definitions for the 16-bit execution unit.
package alu_pkg;
  localparam logic [3:0] OP_REG   = 4'h0;
  localparam logic [3:0] OP_SHIFT = 4'h8;

  localparam logic [3:0] F_AND  = 4'h1;
  localparam logic [3:0] F_OR   = 4'h2;
  localparam logic [3:0] F_XOR  = 4'h3;
  localparam logic [3:0] F_ADD  = 4'h5;
  localparam logic [3:0] F_ADDC = 4'h6;
  localparam logic [3:0] F_ADDU = 4'h7;
  localparam logic [3:0] F_SUB  = 4'h9;
  localparam logic [3:0] F_SUBC = 4'hA;
  localparam logic [3:0] F_CMP  = 4'hB;
  localparam logic [3:0] F_MOV  = 4'hD;
  localparam logic [3:0] F_MUL  = 4'hE;
  localparam logic [3:0] F_LSH  = 4'h4;
  localparam logic [3:0] F_ASHU = 4'h6;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;
  typedef enum logic [1:0] {M_SHL, M_SHR, M_MUL} iter_mode_e;

  // flags = {C,L,F,Z,N}
  localparam int FL_N = 0;
  localparam int FL_Z = 1;
  localparam int FL_F = 2;
  localparam int FL_L = 3;
  localparam int FL_C = 4;
endpackage

// File: rtl/alu_iter_datapath.sv
// Iterative shift / shift-add multiply accumulator with its step counter.
module alu_iter_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [1:0]       mode,
  input  logic             fill,
  input  logic [WIDTH-1:0] dst,
  input  logic [WIDTH-1:0] src,
  input  logic [CW-1:0]    cnt_in,
  output logic [WIDTH-1:0] acc_nxt,
  output logic             last
);
  logic [WIDTH-1:0] acc, mcand, mplr;
  logic [CW-1:0]    cnt;
  logic [1:0]       mode_q;
  logic             fill_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplr   <= '0;
      cnt    <= '0;
      mode_q <= M_SHL;
      fill_q <= 1'b0;
    end else if (load) begin
      acc    <= (mode == M_MUL) ? '0 : dst;
      mcand  <= dst;
      mplr   <= src;
      cnt    <= cnt_in;
      mode_q <= mode;
      fill_q <= fill;
    end else if (step) begin
      acc    <= acc_nxt;
      mcand  <= {mcand[WIDTH-2:0], 1'b0};
      mplr   <= {1'b0, mplr[WIDTH-1:1]};
      cnt    <= cnt - CW'(1);
    end
  end

  // Value after the current step; the top captures it on the final step.
  always_comb begin
    acc_nxt = acc;
    case (mode_q)
      M_SHL:   acc_nxt = {acc[WIDTH-2:0], 1'b0};
      M_SHR:   acc_nxt = {fill_q, acc[WIDTH-1:1]};
      M_MUL:   acc_nxt = acc + (mplr[0] ? mcand : '0);
      default: acc_nxt = acc;
    endcase
  end

  assign last = (cnt == CW'(1));
endmodule

// File: rtl/alu_exec_unit.sv
// Execution unit: decode, single-cycle ALU, status flags and the start/done FSM
// wrapped around the iterative shift/multiply datapath.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       oper,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] dst,
  input  logic [WIDTH-1:0] src,
  output logic             ready,
  output logic             done,
  output logic             wr_en,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);
  localparam int CW = $clog2(WIDTH) + 1;

  state_e           state, nxt;
  logic             accept, wr_q, err_q;
  logic             legal, wb, ifill, last;
  logic [1:0]       imode;
  logic [CW-1:0]    n;
  logic [WIDTH-1:0] alu_res, acc_nxt;
  logic [4:0]       alu_fl;
  logic [WIDTH:0]   add_w, sub_w;
  logic             cin_add, cin_sub, ovf_add, ovf_sub;
  logic [SHW-1:0]   amt, amt_abs;

  assign ready  = (state == IDLE) || (state == DONE);
  assign accept = start && ready;
  assign done   = (state == DONE);
  assign wr_en  = done && wr_q;
  assign err    = done && err_q;

  assign cin_add = (func == F_ADDC) && flags[FL_C];
  assign cin_sub = (func == F_SUBC) && flags[FL_C];
  assign add_w   = {1'b0, dst} + {1'b0, src} + {{WIDTH{1'b0}}, cin_add};
  assign sub_w   = {1'b0, dst} - {1'b0, src} - {{WIDTH{1'b0}}, cin_sub};
  assign ovf_add = (dst[WIDTH-1] == src[WIDTH-1]) && (add_w[WIDTH-1] != dst[WIDTH-1]);
  assign ovf_sub = (dst[WIDTH-1] != src[WIDTH-1]) && (sub_w[WIDTH-1] != dst[WIDTH-1]);

  // Most negative amount has no positive twin in SHW bits but reads back as 2^(SHW-1) unsigned.
  assign amt     = src[SHW-1:0];
  assign amt_abs = amt[SHW-1] ? -amt : amt;

  always_comb begin
    legal   = 1'b0;
    wb      = 1'b1;
    n       = '0;
    imode   = M_SHL;
    ifill   = 1'b0;
    alu_res = result;
    alu_fl  = flags;
    if (oper == OP_REG) begin
      legal = 1'b1;
      case (func)
        F_AND:  alu_res = dst & src;
        F_OR:   alu_res = dst | src;
        F_XOR:  alu_res = dst ^ src;
        F_MOV:  alu_res = src;
        F_ADDU: alu_res = add_w[WIDTH-1:0];
        F_ADD, F_ADDC: begin
          alu_res      = add_w[WIDTH-1:0];
          alu_fl[FL_C] = add_w[WIDTH];
          alu_fl[FL_F] = ovf_add;
        end
        F_SUB, F_SUBC: begin
          alu_res      = sub_w[WIDTH-1:0];
          alu_fl[FL_C] = sub_w[WIDTH];
          alu_fl[FL_F] = ovf_sub;
        end
        F_CMP: begin
          wb           = 1'b0;
          alu_fl[FL_Z] = (dst == src);
          alu_fl[FL_L] = (dst < src);
          alu_fl[FL_N] = ($signed(dst) < $signed(src));
        end
        F_MUL: begin
          n     = CW'(WIDTH);
          imode = M_MUL;
        end
        default: legal = 1'b0;
      endcase
    end else if (oper == OP_SHIFT && (func == F_LSH || func == F_ASHU)) begin
      legal   = 1'b1;
      alu_res = dst;
      n       = CW'(amt_abs);
      imode   = amt[SHW-1] ? M_SHR : M_SHL;
      ifill   = (func == F_ASHU) && amt[SHW-1] && dst[WIDTH-1];
    end
  end

  always_comb begin
    nxt = state;
    if (accept)
      nxt = (n != '0) ? ITER : DONE;
    else if (state == ITER)
      nxt = last ? DONE : ITER;
    else if (state == DONE)
      nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      result <= '0;
      flags  <= '0;
      wr_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        wr_q  <= legal && wb;
        err_q <= !legal;
        if (legal && n == '0) begin
          if (wb) result <= alu_res;
          flags <= alu_fl;
        end
      end else if (state == ITER && last) begin
        result <= acc_nxt;
      end
    end
  end

  alu_iter_datapath #(.WIDTH(WIDTH), .CW(CW)) u_iter (
    .clk     (clk),
    .reset   (reset),
    .load    (accept && n != '0),
    .step    (state == ITER),
    .mode    (imode),
    .fill    (ifill),
    .dst     (dst),
    .src     (src),
    .cnt_in  (n),
    .acc_nxt (acc_nxt),
    .last    (last)
  );
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed plus randomized checks of alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  oper, func;
  logic [15:0] dst, src;
  logic        ready, done, wr_en, err;
  logic [15:0] result;
  logic [4:0]  flags;

  int          n_chk = 0, n_err = 0;
  logic [15:0] m_result;
  logic [4:0]  m_flags;

  alu_exec_unit #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .oper(oper), .func(func),
    .dst(dst), .src(src), .ready(ready), .done(done), .wr_en(wr_en),
    .err(err), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: expected result/flags/writeback/error and cycles-to-done from the operation rules.
  task automatic model(input logic [3:0] op, input logic [3:0] fn, input logic [15:0] d,
                       input logic [15:0] s, output logic [15:0] r, output logic [4:0] f,
                       output bit w, output bit e, output int lat);
    int sd, ss, t, ts, a, cin;
    logic [31:0] p;
    r = m_result; f = m_flags; w = 1; e = 0; lat = 1;
    sd = $signed(d); ss = $signed(s); cin = int'(m_flags[4]);
    if (op == 4'h0) begin
      case (fn)
        4'h1: r = d & s;
        4'h2: r = d | s;
        4'h3: r = d ^ s;
        4'hD: r = s;
        4'h7: begin t = int'(d) + int'(s); r = t[15:0]; end
        4'h5, 4'h6: begin
          if (fn == 4'h5) cin = 0;
          t = int'(d) + int'(s) + cin; ts = sd + ss + cin;
          r = t[15:0]; f[4] = (t > 65535); f[2] = (ts > 32767 || ts < -32768);
        end
        4'h9, 4'hA: begin
          if (fn == 4'h9) cin = 0;
          t = int'(d) - int'(s) - cin; ts = sd - ss - cin;
          r = t[15:0]; f[4] = (t < 0); f[2] = (ts > 32767 || ts < -32768);
        end
        4'hB: begin w = 0; f[1] = (d == s); f[3] = (d < s); f[0] = (sd < ss); end
        4'hE: begin p = 32'(d) * 32'(s); r = p[15:0]; lat = 17; end
        default: begin e = 1; w = 0; end
      endcase
    end else if (op == 4'h8 && (fn == 4'h4 || fn == 4'h6)) begin
      a = int'(s[4:0]);
      if (a > 15) a -= 32;
      if (a >= 0) begin
        p = {16'h0, d} << a; r = p[15:0]; lat = 1 + a;
      end else begin
        lat = 1 - a;
        if (fn == 4'h6) begin t = sd >>> (-a); r = t[15:0]; end
        else begin p = {16'h0, d} >> (-a); r = p[15:0]; end
      end
    end else begin
      e = 1; w = 0;
    end
  endtask

  // Issue at a negedge with ready=1; returns at the negedge of the done cycle,
  // so an immediately following call issues back-to-back.
  task automatic run_op(input logic [3:0] op, input logic [3:0] fn, input logic [15:0] d,
                        input logic [15:0] s, input int poke);
    logic [15:0] er; logic [4:0] ef; bit ew, ee; int lat, c;
    chk("ready_at_issue", 32'(ready), 1);
    model(op, fn, d, s, er, ef, ew, ee, lat);
    oper = op; func = fn; dst = d; src = s; start = 1'b1;
    @(negedge clk); start = 1'b0; c = 1;
    while (!done && c < 40) begin
      if (c == poke) begin
        chk("busy_not_ready", 32'(ready), 0);
        oper = 4'h0; func = 4'hB; dst = 16'h0000; src = 16'h0001; start = 1'b1;
      end
      @(negedge clk); start = 1'b0; c++;
    end
    chk("latency", 32'(c), 32'(lat));
    chk("result", 32'(result), 32'(er));
    chk("flags", 32'(flags), 32'(ef));
    chk("wr_en", 32'(wr_en), 32'(ew));
    chk("err", 32'(err), 32'(ee));
    m_result = er; m_flags = ef;
  endtask

  logic [7:0] optab [13] = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h07, 8'h09,
                             8'h0A, 8'h0B, 8'h0D, 8'h0E, 8'h84, 8'h86};

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int seen;
    logic [7:0] of;
    reset = 1'b1; start = 1'b0; oper = '0; func = '0; dst = '0; src = '0;
    m_result = '0; m_flags = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_result", 32'(result), 0);
    chk("rst_flags", 32'(flags), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ready", 32'(ready), 1);

    run_op(4'h0, 4'h5, 16'h7FFF, 16'h0001, 0);
    chk("add_ovf_res", 32'(result), 32'h8000);
    chk("add_ovf_F", 32'(flags[2]), 1);
    chk("add_ovf_C", 32'(flags[4]), 0);

    run_op(4'h0, 4'h5, 16'hFFFF, 16'h0001, 0);
    chk("add_carry_C", 32'(flags[4]), 1);
    run_op(4'h0, 4'h6, 16'h0001, 16'h0001, 0);
    chk("addc_b2b_res", 32'(result), 32'h0003);

    run_op(4'h8, 4'h6, 16'h8000, 16'h001D, 0);
    chk("ashu_r3", 32'(result), 32'hF000);
    run_op(4'h8, 4'h4, 16'h8000, 16'h001D, 0);
    chk("lsh_r3", 32'(result), 32'h1000);
    run_op(4'h8, 4'h4, 16'h8000, 16'h0004, 0);
    run_op(4'h8, 4'h4, 16'h1234, 16'h0000, 0);
    run_op(4'h8, 4'h4, 16'hFFFF, 16'h0010, 0);
    chk("lsh_m16", 32'(result), 0);
    run_op(4'h8, 4'h6, 16'h8001, 16'h0010, 0);
    chk("ashu_m16", 32'(result), 32'hFFFF);

    run_op(4'h0, 4'hE, 16'h0123, 16'h0010, 5);
    chk("mul_res", 32'(result), 32'h1230);

    run_op(4'h0, 4'hB, 16'h0001, 16'hFFFF, 0);
    chk("cmp_L", 32'(flags[3]), 1);
    chk("cmp_N", 32'(flags[0]), 0);
    chk("cmp_Z", 32'(flags[1]), 0);

    // Reset in the middle of a multiply
    oper = 4'h0; func = 4'hE; dst = 16'h0123; src = 16'h0010; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c < 6; c++) begin
      chk("abort_pre_done", 32'(done), 0);
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    m_result = '0; m_flags = '0;
    chk("abort_ready", 32'(ready), 1);
    chk("abort_done", 32'(done), 0);
    chk("abort_flags", 32'(flags), 0);
    chk("abort_result", 32'(result), 0);
    seen = 0;
    repeat (20) begin @(negedge clk); if (done) seen++; end
    chk("abort_no_done", 32'(seen), 0);

    run_op(4'h3, 4'h1, 16'h1111, 16'h2222, 0);
    chk("illegal_err", 32'(err), 1);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) of = 8'($urandom);
      else of = optab[$urandom_range(0, 12)];
      run_op(of[7:4], of[3:0], pick(), pick(), 0);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle execution unit for the 16-bit datapath. It decodes `oper`/`func`, runs single-cycle logic and arithmetic directly, and iterates shifts and multiply one step per cycle behind a start/done handshake. It owns the processor status flags (C, L, F, Z, N) and sits between the decode stage and register-file writeback.

## Interface

Parameters:
- `WIDTH`, default 16: datapath width; must be ≥ 4 and a power of two.
- `SHW`, default `$clog2(WIDTH)+1`: width of the signed shift-amount field taken from `src[SHW-1:0]`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request; accepted only while `ready`=1.
- `oper`  in  4  major opcode.
- `func`  in  4  function field.
- `dst`  in  WIDTH  destination operand.
- `src`  in  WIDTH  source operand.
- `ready`  out  1  can accept `start` this cycle.
- `done`  out  1  one-cycle pulse; `result`/`flags` are updated in this cycle.
- `wr_en`  out  1  valid with `done`; register writeback required.
- `err`  out  1  valid with `done`; the opcode was illegal.
- `result`  out  WIDTH  last result; held between operations.
- `flags`  out  5  {C,L,F,Z,N}; held between updates.

## Operation

- Decode for `oper`=0 (register ops), single-cycle:
  - func 1 AND, 2 OR, 3 XOR, D MOV (result = `src`).
  - func 5 ADD and 7 ADDU: `dst`+`src`.
  - func 6 ADDC: `dst`+`src`+C.
  - func 9 SUB: `dst`−`src`.
  - func A SUBC: `dst`−`src`−C.
  - func B CMP.
  - func E MUL: iterative.
- Decode for `oper`=8 (shifts), iterative:
  - `amt` = signed `src[SHW-1:0]`; positive shifts left, negative shifts right.
  - func 4 LSH: zero fill.
  - func 6 ASHU: right shift fills with `dst[WIDTH-1]`; left shift fills with zero.
- Any other `oper`/`func` is illegal: `done` pulses with `err`=1 and `wr_en`=0; `result` and `flags` are unchanged.
- Flag rules:
  - ADD/ADDC: C = unsigned carry-out; F = signed overflow.
  - ADDU: no flag change.
  - SUB/SUBC: C = unsigned borrow; F = signed overflow.
  - CMP: Z = (`dst`==`src`); L = `dst`<`src` unsigned; N = `dst`<`src` signed; `wr_en`=0.
  - All other operations leave `flags` unchanged.
- MUL: shift-add, one bit per cycle, WIDTH iterations; result is the low WIDTH bits of the product (same for signed and unsigned).
- State machine: IDLE → (start) → ITER when step count N>0, else DONE; ITER decrements its counter and moves to DONE after N steps; DONE → IDLE, or → DONE/ITER directly when `start` is accepted in the DONE cycle.
- `ready` = (state==IDLE) || (state==DONE). A `start` seen while `ready`=0 is ignored and not queued.

## Timing

- Operands are captured on the edge where `start`&&`ready`=1 (cycle t).
- `done` is high in cycle t+1+N:
  - N=0 for single-cycle and illegal ops.
  - N=|`amt`| for shifts; `amt`=0 gives N=0 and result = `dst`.
  - N=WIDTH for MUL.
- `amt` = −2^(SHW−1) (i.e. −16 at WIDTH=16): N=WIDTH. LSH result is 0; ASHU result is WIDTH copies of the sign bit.
- Back-to-back issue: `start` accepted in a DONE cycle gives one operation every 1+N+... cycles, with no bubble beyond DONE.
- Reset values: `result`=0, `flags`=0, `done`=`wr_en`=`err`=0, `ready`=1, state IDLE.
- Reset during ITER or DONE aborts the operation: no `done` pulse follows, and `ready`=1 in the next cycle.

## Structure

- Shared package `alu_pkg`:
  - `OP_REG`/`OP_SHIFT` constants.
  - func constants (`F_AND` … `F_MUL`, `F_LSH`, `F_ASHU`).
  - state enum {IDLE, ITER, DONE}.
  - flag bit indices `FL_C`, `FL_L`, `FL_F`, `FL_Z`, `FL_N`.
- One sub-module, `alu_iter_datapath`: the shift/multiply accumulator, step counter and fill logic. The top level holds decode, the FSM, the flag register and the single-cycle ALU.

## Test plan

- ADD `dst`=0x7FFF, `src`=0x0001 → `done` at t+1; `result`=0x8000; F=1, C=0; `wr_en`=1.
- ADD 0xFFFF+0x0001 → 0x0000 with C=1. Then ADDC 0x0001+0x0001 issued in the DONE cycle → 0x0003 at t+1.
- `dst`=0x8000, `src`=0x001D (`amt`=−3):
  - ASHU → 0xF000, `done` at t+4.
  - LSH → 0x1000.
  - LSH with `src`=0x0004 → `dst`<<4 at t+5.
- MUL 0x0123×0x0010 → 0x1230 with `done` at t+17. A `start` pulsed at t+5 is ignored; `flags` are unchanged.
- CMP `dst`=0x0001, `src`=0xFFFF → L=1, N=0, Z=0; `wr_en`=0; `result` is unchanged.
- Reset asserted at t+6 of a MUL → no `done`; `ready`=1, `flags`=0, `result`=0 the next cycle. Then `oper`=3 → `done` with `err`=1 at t+1.
